// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush sequencer: per-stage enables and bubble strobes for the
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB register banks.
module pipeline_stall_ctrl #(
    parameter int unsigned REGW         = 5,
    parameter int unsigned MEM_LAT      = 3,
    parameter int unsigned CNTW         = 4,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_memread,
    input  logic            branch_taken,
    input  logic            mem_req,
    input  logic            halt_req,
    input  logic            resume,
    output logic            en_pc,
    output logic            en_ifid,
    output logic            en_idex,
    output logic            en_exmem,
    output logic            en_memwb,
    output logic            clr_ifid,
    output logic            clr_idex,
    output logic            stall,
    output logic            halted,
    output logic [1:0]      state
);

    if (MEM_LAT == 0 || MEM_LAT > 2**CNTW || DRAIN_CYCLES == 0 ||
        DRAIN_CYCLES >= 2**CNTW) begin : g_bad_params
        $fatal(1, "pipeline_stall_ctrl: illegal MEM_LAT/DRAIN_CYCLES for CNTW");
    end

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StDrain  = 2'b01,
        StHalted = 2'b10
    } state_e;

    localparam logic [CNTW-1:0] MemLatM1  = CNTW'(MEM_LAT - 1);
    localparam logic [CNTW-1:0] DrainInit = CNTW'(DRAIN_CYCLES);
    localparam logic [CNTW-1:0] CntOne    = CNTW'(1);

    state_e          state_q, state_d;
    logic [CNTW-1:0] mem_cnt_q, mem_cnt_d;
    logic [CNTW-1:0] drain_cnt_q, drain_cnt_d;

    logic load_use;
    logic new_access;
    logic freeze;

    assign load_use = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // mem_cnt == 1 is the release cycle; a mem_req seen there is the same access.
    assign new_access = mem_req && (mem_cnt_q == '0) && (MEM_LAT > 1);
    assign freeze     = new_access || (mem_cnt_q > CntOne);

    always_comb begin
        state_d     = state_q;
        mem_cnt_d   = mem_cnt_q;
        drain_cnt_d = drain_cnt_q;
        en_pc       = 1'b0;
        en_ifid     = 1'b0;
        en_idex     = 1'b0;
        en_exmem    = 1'b0;
        en_memwb    = 1'b0;
        clr_ifid    = 1'b0;
        clr_idex    = 1'b0;

        if (new_access) begin
            mem_cnt_d = MemLatM1;
        end else if (mem_cnt_q != '0) begin
            mem_cnt_d = mem_cnt_q - CntOne;
        end

        if (!freeze) begin
            unique case (state_q)
                StRun: begin
                    en_pc    = 1'b1;
                    en_ifid  = 1'b1;
                    en_idex  = 1'b1;
                    en_exmem = 1'b1;
                    en_memwb = 1'b1;
                    if (branch_taken) begin
                        clr_ifid = 1'b1;
                        clr_idex = 1'b1;
                    end else if (load_use) begin
                        en_pc    = 1'b0;
                        en_ifid  = 1'b0;
                        clr_idex = 1'b1;
                    end else if (halt_req) begin
                        state_d     = StDrain;
                        drain_cnt_d = DrainInit;
                    end
                end
                StDrain: begin
                    en_ifid     = 1'b1;
                    en_idex     = 1'b1;
                    en_exmem    = 1'b1;
                    en_memwb    = 1'b1;
                    clr_ifid    = 1'b1;
                    clr_idex    = branch_taken;
                    drain_cnt_d = drain_cnt_q - CntOne;
                    if (drain_cnt_q == CntOne) begin
                        state_d = StHalted;
                    end
                end
                StHalted: begin
                    if (resume) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end

        // Outputs are forced low for the whole time reset is held.
        if (reset) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
            clr_ifid = 1'b0;
            clr_idex = 1'b0;
        end
    end

    assign stall  = !reset && !en_pc;
    assign halted = !reset && (state_q == StHalted);
    assign state  = reset ? 2'b00 : state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            mem_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_cnt_q   <= mem_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-numbered behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int unsigned REGW         = 5;
    localparam int unsigned MEM_LAT      = 3;
    localparam int unsigned CNTW         = 4;
    localparam int unsigned DRAIN_CYCLES = 4;

    // {en_pc,en_ifid,en_idex,en_exmem,en_memwb, clr_ifid,clr_idex, stall, halted, state}
    localparam logic [10:0] VRun      = 11'b11111_00_0_0_00;
    localparam logic [10:0] VFrozen   = 11'b00000_00_1_0_00;
    localparam logic [10:0] VLoadUse  = 11'b00111_01_1_0_00;
    localparam logic [10:0] VBranch   = 11'b11111_11_0_0_00;
    localparam logic [10:0] VDrain    = 11'b01111_10_1_0_01;
    localparam logic [10:0] VDrainFrz = 11'b00000_00_1_0_01;
    localparam logic [10:0] VHalted   = 11'b00000_00_1_1_10;

    logic            clk = 1'b0;
    logic            reset;
    logic [REGW-1:0] id_rs1, id_rs2, ex_rd;
    logic            ex_memread, branch_taken, mem_req, halt_req, resume;
    logic            en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic            clr_ifid, clr_idex, stall, halted;
    logic [1:0]      state;

    int n_cmp = 0;
    int n_err = 0;

    // Model: access release happens at an absolute cycle number; drain counts cycles done.
    int cyc       = 0;
    int m_state   = 0;
    int m_rel     = -1;
    int m_drained = 0;

    pipeline_stall_ctrl #(
        .REGW(REGW), .MEM_LAT(MEM_LAT), .CNTW(CNTW), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .branch_taken(branch_taken), .mem_req(mem_req),
        .halt_req(halt_req), .resume(resume),
        .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
        .en_memwb(en_memwb), .clr_ifid(clr_ifid), .clr_idex(clr_idex),
        .stall(stall), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic m_load_use();
        return ex_memread && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    endfunction

    function automatic logic m_new_access();
        return mem_req && !(cyc <= m_rel) && (MEM_LAT > 1);
    endfunction

    function automatic logic m_frozen();
        return m_new_access() || (cyc < m_rel);
    endfunction

    function automatic logic [10:0] model_out();
        logic [4:0] en;
        logic [1:0] clr;
        en  = '0;
        clr = '0;
        if (reset) return '0;
        if (!m_frozen()) begin
            if (m_state == 0) begin
                if (branch_taken) begin
                    en  = 5'b11111;
                    clr = 2'b11;
                end else if (m_load_use()) begin
                    en  = 5'b00111;
                    clr = 2'b01;
                end else begin
                    en = 5'b11111;
                end
            end else if (m_state == 1) begin
                en  = 5'b01111;
                clr = {1'b1, branch_taken};
            end
        end
        return {en, clr, ~en[4], (m_state == 2), 2'(m_state)};
    endfunction

    task automatic model_adv();
        logic start, frz;
        if (reset) begin
            m_state   = 0;
            m_rel     = -1;
            m_drained = 0;
        end else begin
            start = m_new_access();
            frz   = m_frozen();
            if (start) m_rel = cyc + int'(MEM_LAT) - 1;
            if (!frz) begin
                if (m_state == 0) begin
                    if (!branch_taken && !m_load_use() && halt_req) begin
                        m_state   = 1;
                        m_drained = 0;
                    end
                end else if (m_state == 1) begin
                    m_drained++;
                    if (m_drained == int'(DRAIN_CYCLES)) m_state = 2;
                end else if (resume) begin
                    m_state = 0;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle_inputs();
        reset = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_memread = 0;
        branch_taken = 0; mem_req = 0; halt_req = 0; resume = 0;
    endtask

    // Samples on the falling edge, then advances to just after the next rising edge.
    task automatic tick(output logic [10:0] obs, output logic [10:0] exp);
        @(negedge clk);
        obs = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, clr_ifid, clr_idex,
               stall, halted, state};
        exp = model_out();
        model_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] obs, exp;
        idle_inputs();
        reset = 1; mem_req = 1; branch_taken = 1;
        tick(obs, exp);
        n_cmp++;
        if (obs !== 11'b0) begin
            n_err++; $display("FAIL reset_outputs: got %b want %b", obs, 11'b0);
        end
        idle_inputs();
        tick(obs, exp);
        n_cmp++;
        if (obs !== VRun) begin
            n_err++; $display("FAIL after_reset: got %b want %b", obs, VRun);
        end
    endtask

    task automatic test_load_use();
        logic [10:0] obs, exp;
        idle_inputs();
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 7;
        tick(obs, exp);
        n_cmp++;
        if (obs !== VLoadUse) begin
            n_err++; $display("FAIL load_use: got %b want %b", obs, VLoadUse);
        end
        ex_rd = 0; id_rs2 = 0;
        tick(obs, exp);
        n_cmp++;
        if (obs !== VRun) begin
            n_err++; $display("FAIL load_use_x0: got %b want %b", obs, VRun);
        end
    endtask

    task automatic test_mem_freeze();
        logic [10:0] obs, exp;
        logic [10:0] want [4];
        want = '{VFrozen, VFrozen, VRun, VFrozen};
        idle_inputs();
        mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            tick(obs, exp);
            n_cmp++;
            if (obs !== want[i]) begin
                n_err++; $display("FAIL mem_freeze_c%0d: got %b want %b", i, obs, want[i]);
            end
        end
        mem_req = 0;
        for (int i = 0; i < 3; i++) tick(obs, exp);
        n_cmp++;
        if (obs !== VRun) begin
            n_err++; $display("FAIL mem_freeze_settle: got %b want %b", obs, VRun);
        end
    endtask

    task automatic test_branch_over_load_use();
        logic [10:0] obs, exp;
        idle_inputs();
        branch_taken = 1; ex_memread = 1; ex_rd = 9; id_rs1 = 9;
        tick(obs, exp);
        n_cmp++;
        if (obs !== VBranch) begin
            n_err++; $display("FAIL branch_vs_load_use: got %b want %b", obs, VBranch);
        end
    endtask

    task automatic test_halt_resume();
        logic [10:0] obs, exp;
        idle_inputs();
        halt_req = 1;
        tick(obs, exp);
        n_cmp++;
        if (obs !== VRun) begin
            n_err++; $display("FAIL halt_req_cycle: got %b want %b", obs, VRun);
        end
        halt_req = 0;
        for (int i = 0; i < 4; i++) begin
            halt_req = (i == 1);
            tick(obs, exp);
            n_cmp++;
            if (obs !== VDrain) begin
                n_err++; $display("FAIL drain_c%0d: got %b want %b", i, obs, VDrain);
            end
        end
        halt_req = 0;
        for (int i = 0; i < 2; i++) begin
            tick(obs, exp);
            n_cmp++;
            if (obs !== VHalted) begin
                n_err++; $display("FAIL halted_c%0d: got %b want %b", i, obs, VHalted);
            end
        end
        resume = 1;
        tick(obs, exp);
        n_cmp++;
        if (obs !== VHalted) begin
            n_err++; $display("FAIL resume_cycle: got %b want %b", obs, VHalted);
        end
        resume = 0;
        tick(obs, exp);
        n_cmp++;
        if (obs !== VRun) begin
            n_err++; $display("FAIL after_resume: got %b want %b", obs, VRun);
        end
    endtask

    task automatic test_drain_freeze_and_abort();
        logic [10:0] obs, exp;
        int drain_cycles;
        idle_inputs();
        halt_req = 1;
        tick(obs, exp);
        halt_req = 0;
        drain_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            mem_req = (i == 0);
            tick(obs, exp);
            if (i == 0) begin
                n_cmp++;
                if (obs !== VDrainFrz) begin
                    n_err++; $display("FAIL drain_freeze: got %b want %b", obs, VDrainFrz);
                end
            end
            if (obs[1:0] == 2'b01) drain_cycles++;
            else break;
        end
        n_cmp++;
        if (drain_cycles != 6) begin
            n_err++; $display("FAIL drain_len_with_freeze: got %0d want 6", drain_cycles);
        end
        resume = 1;
        tick(obs, exp);
        idle_inputs();
        tick(obs, exp);
        halt_req = 1;
        tick(obs, exp);
        halt_req = 0; mem_req = 1;
        tick(obs, exp);
        mem_req = 0; reset = 1;
        tick(obs, exp);
        n_cmp++;
        if (obs !== 11'b0) begin
            n_err++; $display("FAIL reset_mid_drain: got %b want %b", obs, 11'b0);
        end
        reset = 0;
        tick(obs, exp);
        n_cmp++;
        if (obs !== VRun) begin
            n_err++; $display("FAIL no_pending_freeze: got %b want %b", obs, VRun);
        end
    endtask

    task automatic test_random();
        logic [10:0] obs, exp;
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            id_rs1       = REGW'($urandom_range(0, 3));
            id_rs2       = REGW'($urandom_range(0, 3));
            ex_rd        = REGW'($urandom_range(0, 3));
            ex_memread   = $urandom_range(0, 1) == 1;
            branch_taken = ($urandom_range(0, 7) == 0);
            mem_req      = ($urandom_range(0, 5) == 0);
            halt_req     = ($urandom_range(0, 15) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            tick(obs, exp);
            n_cmp++;
            if (obs !== exp) begin
                n_err++; $display("FAIL random_c%0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_mem_freeze();
        test_branch_over_load_use();
        test_halt_resume();
        test_drain_freeze_and_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
